smc_seq_ctrl: RTL and testbench
===============================

Name: smc_seq_ctrl

Overview:
- Sequential front-end and scheduler for the MOSFET current/transconductance scoring datapath.
- Accepts six transistor descriptors (W, V_GS, V_DS) serially over a valid/ready handshake.
- Time-shares one current/gm evaluation unit across the six beats and maintains a running top-3 selection.
- Produces the weighted 10-bit score with an output valid/ready handshake. Replaces the six parallel evaluators with one.

Parameters:
N_DEV, 6, transistor descriptors per job; fixed 6 in this revision, counter sized ceil(log2(N_DEV+1))
TIMEOUT, 15, idle cycles tolerated mid-job; used only with SMC_SEQ_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  descriptor beat valid
in_ready  out  1  controller can accept a beat
mode  in  2  [0]=1 current / 0 gm; [1]=1 largest three / 0 smallest three; sampled on first beat only
W  in  3  channel width
V_GS  in  3  gate-source voltage
V_DS  in  3  drain-source voltage
out_valid  out  1  result valid; held until accepted
out_ready  in  1  consumer accepts result
out_n  out  10  weighted score
busy  out  1  job in progress (first beat accepted, result not yet accepted)
err  out  1  one-cycle timeout abort pulse; tied 0 without the optional feature

Behaviour:
- Reset, asynchronous: state=IDLE, beat count=0, top-3 registers=0, mode register=0, out_n=0, out_valid=0, busy=0, err=0. in_ready=1 once reset deasserts.
- Beat accepted on a clk edge with in_valid && in_ready. Gaps with in_valid low are allowed and do not count.
- Evaluation per beat, combinational within the accept cycle:
  - Vov = V_GS-1, 3-bit wrap (V_GS=0 gives 7).
  - If Vov > V_DS (triode): I = W*(2*Vov*V_DS - V_DS^2), g = W*2*V_DS.
  - Else (saturation): I = W*Vov^2, g = W*2*Vov.
  - I and g are truncated to 8 bits (mod 256).
- Selection key: the metric chosen by mode[0]. If mode[1]=0, the key is bit-inverted so that a single top-3 inserter serves both directions. Ties are kept in arrival order; this has no effect on the result.
- FSM:
  - IDLE: in_ready=1. On first beat: latch mode, insert its key, count=1, go to LOAD.
  - LOAD: in_ready=1. Each beat inserts its key into the sorted top-3 registers (a>=b>=c) and increments count. The beat that makes count=N_DEV goes to CALC.
  - CALC (1 cycle): in_ready=0.
    - Un-invert the registers if mode[1]=0.
    - Order the three selected values descending: x>=y>=z.
    - Divide each by 3, floor, 7-bit.
    - gm mode: out_n = x'+y'+z'. Current mode: out_n = 3x'+4y'+5z'. Maximum 1020 fits in 10 bits.
    - Register out_n, set out_valid=1, go to OUT.
  - OUT: in_ready=0; out_n and out_valid held stable. On out_valid && out_ready: out_valid=0, busy=0, top-3 and count cleared, go to IDLE. out_n keeps its last value.
- Latency: out_valid rises on the first edge after the edge accepting beat 6, so it is visible in the following cycle. Minimum job length is 7 cycles plus the output handshake.
- Throughput: a new job's first beat is accepted in the cycle after result acceptance, never in the same cycle.
- In IDLE, mode is ignored when in_valid=0. Mode values on beats 2..6 are ignored.
- in_valid asserted while in_ready=0 is ignored, with no state change.
- rst mid-job (any state) aborts immediately to reset values, and partial results are discarded.

Optional Feature:
- Macro: SMC_SEQ_TIMEOUT_EN.
- Enabled: an idle counter runs in LOAD and clears on every accepted beat. After TIMEOUT consecutive cycles with no beat, the block pulses err for 1 cycle, clears count and top-3, drops busy, and returns to IDLE. No out_valid is produced.
- Disabled: no counter, err tied 0, and LOAD waits indefinitely.

Test Plan:
- Descriptors k=1..6: W=k, V_GS=4, V_DS=7 (saturation, I=9k, g=6k), mode=2'b11 -> out_n=174 (54,45,36 -> 18,15,12 -> 54+60+60). out_valid appears 1 cycle after the CALC edge.
- Same descriptors, mode=2'b01 -> 66. mode=2'b10 -> 30. mode=2'b00 -> 12.
- Same descriptors with mode changed on beats 2..6 and in_valid gaps of 0-3 cycles -> result equals first-beat-mode value. in_ready=0 only in CALC/OUT.
- Wrap/truncation: one beat W=7, V_GS=0, V_DS=7 (I=343 -> 87), other five beats W=1, V_GS=2, V_DS=0 (I=0), mode=2'b11 -> out_n=3*29=87.
- Hold out_ready=0 for 5 cycles in OUT -> out_n/out_valid stable, in_valid beats ignored. Accept -> IDLE next cycle. Then rst pulse after beat 3 of the next job -> all outputs reset, and a following full job scores correctly.
- With SMC_SEQ_TIMEOUT_EN, TIMEOUT=15: 2 beats then 15 idle cycles -> err pulse, busy=0, no out_valid. Without the macro: same stimulus, block stays in LOAD with busy=1.

Source files
------------

// File: rtl/smc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// smc_seq_ctrl
//
// Sequential front-end and scheduler for the MOSFET current/transconductance
// scoring datapath. Six transistor descriptors (W, V_GS, V_DS) arrive serially.
// One shared evaluator computes drain current I and transconductance g for
// each beat. A running top-3 inserter keeps the three selected keys, and a
// one-cycle CALC step turns them into a weighted 10-bit score.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. out_valid, once raised, is held with out_n
// stable until out_ready is seen. in_valid while in_ready=0 is ignored.
//
// Optional feature macro: SMC_SEQ_TIMEOUT_EN
//   When defined, a job stalled in LOAD for TIMEOUT consecutive beat-less
//   cycles is aborted: err pulses for one cycle and the block returns to IDLE.
//   When undefined, err is tied 0 and LOAD waits indefinitely.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   descriptor beat valid
//   in_ready   out  1   controller can accept a beat (IDLE/LOAD)
//   mode       in   2   [0]=1 current / 0 gm; [1]=1 largest 3 / 0 smallest 3
//   W          in   3   channel width
//   V_GS       in   3   gate-source voltage
//   V_DS       in   3   drain-source voltage
//   out_valid  out  1   result valid, held until accepted
//   out_ready  in   1   consumer accepts result
//   out_n      out  10  weighted score
//   busy       out  1   job in progress
//   err        out  1   one-cycle timeout abort pulse
//   dbg_state  out  2   FSM state (0 IDLE, 1 LOAD, 2 CALC, 3 OUT)
// -----------------------------------------------------------------------------
module smc_seq_ctrl #(
    parameter int N_DEV   = 6,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] mode,
    input  logic [2:0] W,
    input  logic [2:0] V_GS,
    input  logic [2:0] V_DS,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_n,
    output logic       busy,
    output logic       err,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(N_DEV + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(N_DEV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_a, r_b, r_c;
    logic [1:0]    r_mode;
    logic [9:0]    r_out_n;
    logic          r_out_valid;

    logic          w_accept;
    logic [1:0]    w_mode_eff;
    logic [2:0]    w_vov;
    logic [7:0]    w_w8, w_vov8, w_vds8;
    logic [7:0]    w_i, w_g, w_key;
    logic [7:0]    w_a_ins, w_b_ins, w_c_ins;
    logic [7:0]    w_x, w_y, w_z;
    logic [9:0]    w_xd, w_yd, w_zd;
    logic [9:0]    w_score;
    logic          w_timeout;

    assign in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_n     = r_out_n;
    assign dbg_state = r_state;
    assign w_accept  = in_valid && in_ready;

    // The first beat uses the live mode input; later beats use the latched copy.
    assign w_mode_eff = (r_state == S_IDLE) ? mode : r_mode;

    // Shared evaluator. All operands are 8 bits wide so every product and
    // difference is computed mod 256, which is exactly the required truncation.
    assign w_vov  = V_GS - 3'd1;
    assign w_w8   = {5'd0, W};
    assign w_vov8 = {5'd0, w_vov};
    assign w_vds8 = {5'd0, V_DS};

    always_comb begin
        w_i = 8'd0;
        w_g = 8'd0;
        if (w_vov > V_DS) begin
            // triode
            w_i = w_w8 * ((8'd2 * w_vov8 * w_vds8) - (w_vds8 * w_vds8));
            w_g = 8'd2 * w_w8 * w_vds8;
        end else begin
            // saturation
            w_i = w_w8 * w_vov8 * w_vov8;
            w_g = 8'd2 * w_w8 * w_vov8;
        end
    end

    // Inverting the key for "smallest three" lets one largest-first inserter
    // serve both selection directions.
    always_comb begin
        w_key = w_mode_eff[0] ? w_i : w_g;
        if (!w_mode_eff[1]) begin
            w_key = ~w_key;
        end
    end

    // Sorted insert into a >= b >= c. Strict compares keep equal keys in
    // arrival order.
    always_comb begin
        w_a_ins = r_a;
        w_b_ins = r_b;
        w_c_ins = r_c;
        if (w_key > r_a) begin
            w_a_ins = w_key;
            w_b_ins = r_a;
            w_c_ins = r_b;
        end else if (w_key > r_b) begin
            w_b_ins = w_key;
            w_c_ins = r_b;
        end else if (w_key > r_c) begin
            w_c_ins = w_key;
        end
    end

    // Un-inverting reverses the order, so for smallest-three the descending
    // triple is (~c, ~b, ~a).
    assign w_x = r_mode[1] ? r_a : ~r_c;
    assign w_y = r_mode[1] ? r_b : ~r_b;
    assign w_z = r_mode[1] ? r_c : ~r_a;

    assign w_xd = {2'b00, w_x} / 10'd3;
    assign w_yd = {2'b00, w_y} / 10'd3;
    assign w_zd = {2'b00, w_z} / 10'd3;

    assign w_score = r_mode[0] ? ((10'd3 * w_xd) + (10'd4 * w_yd) + (10'd5 * w_zd))
                               : (w_xd + w_yd + w_zd);

`ifdef SMC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_idle;
    logic          r_err;

    // Fires on the edge that ends the TIMEOUT-th consecutive beat-less cycle.
    assign w_timeout = (r_state == S_LOAD) && !w_accept && (r_idle == TW'(TIMEOUT - 1));
    assign err       = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if ((r_state != S_LOAD) || w_accept || w_timeout) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + TW'(1);
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_c         <= 8'd0;
            r_mode      <= 2'd0;
            r_out_n     <= 10'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode  <= mode;
                        r_a     <= w_a_ins;
                        r_b     <= w_b_ins;
                        r_c     <= w_c_ins;
                        r_cnt   <= CW'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_a   <= w_a_ins;
                        r_b   <= w_b_ins;
                        r_c   <= w_c_ins;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST_BEAT) begin
                            r_state <= S_CALC;
                        end
                    end else if (w_timeout) begin
                        r_a     <= 8'd0;
                        r_b     <= 8'd0;
                        r_c     <= 8'd0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_out_n     <= w_score;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_a         <= 8'd0;
                        r_b         <= 8'd0;
                        r_c         <= 8'd0;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_smc_seq_ctrl
//
// Bench for smc_seq_ctrl. A transaction-level model tracks beats, the pending
// calculation, the held result and (optionally) the stall timeout, and scores
// a job by sorting the six metrics. One compare process checks every output
// on every falling edge; literal expectations pin the scoring model.
// -----------------------------------------------------------------------------
module tb_smc_seq_ctrl;

  localparam int TIMEOUT = 15;

  typedef int arr6_t [6];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] mode = 2'd0;
  logic [2:0] W = 3'd0;
  logic [2:0] V_GS = 3'd0;
  logic [2:0] V_DS = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] out_n;
  logic       busy;
  logic       err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  arr6_t d_w, d_vgs, d_vds;

  smc_seq_ctrl #(.N_DEV(6), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .W         (W),
    .V_GS      (V_GS),
    .V_DS      (V_DS),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n     (out_n),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoring model ----------------
  function automatic int model_score(input arr6_t w, input arr6_t vgs, input arr6_t vds,
                                     input logic [1:0] md);
    int k[6];
    int s[3];
    int vov, ii, gg, t;
    for (int i = 0; i < 6; i++) begin
      vov = (vgs[i] + 7) % 8;
      if (vov > vds[i]) begin
        ii = w[i] * (2 * vov * vds[i] - vds[i] * vds[i]);
        gg = 2 * w[i] * vds[i];
      end else begin
        ii = w[i] * vov * vov;
        gg = 2 * w[i] * vov;
      end
      k[i] = md[0] ? (ii % 256) : (gg % 256);
    end
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 5 - i; j++)
        if (k[j] > k[j+1]) begin
          t = k[j]; k[j] = k[j+1]; k[j+1] = t;
        end
    if (md[1]) begin
      s[0] = k[5]; s[1] = k[4]; s[2] = k[3];
    end else begin
      s[0] = k[2]; s[1] = k[1]; s[2] = k[0];
    end
    for (int i = 0; i < 3; i++) s[i] = s[i] / 3;
    return md[0] ? (3 * s[0] + 4 * s[1] + 5 * s[2]) : (s[0] + s[1] + s[2]);
  endfunction

  // ---------------- transaction model ----------------
  int         m_beats = 0;
  bit         m_calc = 0;
  bit         m_outv = 0;
  int         m_outn = 0;
  bit         m_err = 0;
  int         m_idle = 0;
  logic [1:0] m_mode = 2'd0;
  arr6_t      m_w, m_vgs, m_vds;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_beats = 0; m_calc = 0; m_outv = 0; m_outn = 0; m_err = 0; m_idle = 0; m_mode = 2'd0;
    end else begin
      m_err = 0;
      if (m_outv) begin
        if (out_ready) m_outv = 0;
      end else if (m_calc) begin
        m_outn = model_score(m_w, m_vgs, m_vds, m_mode);
        m_outv = 1;
        m_calc = 0;
        m_beats = 0;
      end else if (in_valid) begin
        if (m_beats == 0) m_mode = mode;
        m_w[m_beats] = int'(W);
        m_vgs[m_beats] = int'(V_GS);
        m_vds[m_beats] = int'(V_DS);
        m_beats++;
        m_idle = 0;
        if (m_beats == 6) m_calc = 1;
      end else if (m_beats > 0) begin
`ifdef SMC_SEQ_TIMEOUT_EN
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_err = 1;
          m_beats = 0;
          m_idle = 0;
        end
`endif
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(m_outv));
    chk("out_n", int'(out_n), m_outn);
    chk("busy", int'(busy), int'((m_beats > 0) || m_calc || m_outv));
    chk("err", int'(err), int'(m_err));
    if (!rst) chk("in_ready", int'(in_ready), int'(!(m_calc || m_outv)));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_beat(input int i, input logic [1:0] md);
    in_valid = 1'b1;
    W = 3'(d_w[i]);
    V_GS = 3'(d_vgs[i]);
    V_DS = 3'(d_vds[i]);
    mode = md;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [1:0] md, input bit vary, input int max_gap, input int hold);
    int wait_n;
    for (int i = 0; i < 6; i++) begin
      drive_beat(i, (i == 0 || !vary) ? md : 2'($urandom_range(0, 3)));
      if (i < 5) repeat ($urandom_range(0, max_gap)) tick();
    end
    wait_n = 0;
    while (!out_valid && wait_n < 20) begin
      tick();
      wait_n++;
    end
    chk("result_latency", wait_n, 1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      W = 3'($urandom_range(0, 7));
      mode = 2'($urandom_range(0, 3));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic load_plan_vectors();
    for (int k = 1; k <= 6; k++) begin
      d_w[k-1] = k; d_vgs[k-1] = 4; d_vds[k-1] = 7;
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_n", int'(out_n), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", int'(in_ready), 1);

    // Pin the scoring model with hand-computed values.
    load_plan_vectors();
    chk("model_11", model_score(d_w, d_vgs, d_vds, 2'b11), 174);
    chk("model_01", model_score(d_w, d_vgs, d_vds, 2'b01), 66);
    chk("model_10", model_score(d_w, d_vgs, d_vds, 2'b10), 30);
    chk("model_00", model_score(d_w, d_vgs, d_vds, 2'b00), 12);

    run_job(2'b11, 0, 0, 0);
    chk("job_11", int'(out_n), 174);
    run_job(2'b01, 0, 0, 5);
    chk("job_01_hold", int'(out_n), 66);
    chk("idle_after_accept", int'(in_ready), 1);
    run_job(2'b10, 0, 0, 0);
    chk("job_10", int'(out_n), 30);
    run_job(2'b00, 0, 0, 1);
    chk("job_00", int'(out_n), 12);
    run_job(2'b11, 1, 3, 2);
    chk("job_11_vary_mode", int'(out_n), 174);

    // Wrap / truncation case.
    for (int i = 0; i < 6; i++) begin
      d_w[i] = 1; d_vgs[i] = 2; d_vds[i] = 0;
    end
    d_w[2] = 7; d_vgs[2] = 0; d_vds[2] = 7;
    chk("model_wrap", model_score(d_w, d_vgs, d_vds, 2'b11), 87);
    run_job(2'b11, 0, 1, 0);
    chk("job_wrap", int'(out_n), 87);

    // Reset mid-job after beat 3, then a full job.
    load_plan_vectors();
    for (int i = 0; i < 3; i++) drive_beat(i, 2'b11);
    rst = 1'b1;
    #1;
    chk("midjob_reset_busy", int'(busy), 0);
    chk("midjob_reset_out_n", int'(out_n), 0);
    chk("midjob_reset_out_valid", int'(out_valid), 0);
    tick();
    rst = 1'b0;
    tick();
    run_job(2'b11, 0, 2, 0);
    chk("job_after_reset", int'(out_n), 174);

    // Stall: two beats then TIMEOUT idle cycles.
    drive_beat(0, 2'b11);
    drive_beat(1, 2'b11);
    repeat (TIMEOUT + 1) tick();
`ifdef SMC_SEQ_TIMEOUT_EN
    chk("stall_busy", int'(busy), 0);
`else
    chk("stall_busy", int'(busy), 1);
    chk("stall_ready", int'(in_ready), 1);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < 6; i++) begin
        d_w[i] = $urandom_range(0, 7);
        d_vgs[i] = $urandom_range(0, 7);
        d_vds[i] = $urandom_range(0, 7);
      end
      run_job(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
